// File: rtl/sgbm_pixel_timing_gen.sv
// Pixel/line/frame scan generator for the SGBM pipeline: waits for a stable PLL lock, then walks
// IMG_W x IMG_H coordinates under a valid/ready handshake. Optional frame counter: SGBM_TIMING_FRAME_CNT_EN.
module sgbm_pixel_timing_gen #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int H_BLANK   = 16,
    parameter int V_BLANK   = 4,
    parameter int LOCK_WAIT = 256,
    parameter int XW        = 10,
    parameter int YW        = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pll_locked_i,
    input  logic          enable_i,
    input  logic          ready_i,
    output logic          pix_valid_o,
    output logic [XW-1:0] pix_x_o,
    output logic [YW-1:0] pix_y_o,
    output logic          sof_o,
    output logic          eof_o,
    output logic          sol_o,
    output logic          eol_o,
`ifdef SGBM_TIMING_FRAME_CNT_EN
    output logic [15:0]   frame_cnt_o,
`endif
    output logic          busy_o
);

    localparam int LW   = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_WAIT - 1);
    localparam logic [BW-1:0] H_LAST    = BW'(H_BLANK - 1);
    localparam logic [BW-1:0] V_LAST    = BW'(V_BLANK - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_LOCK,
        S_IDLE,
        S_ACTIVE,
        S_HBLANK,
        S_VBLANK
    } state_t;

    state_t         state_q;
    logic [LW-1:0]  lock_cnt_q;
    logic [BW-1:0]  blank_cnt_q;
    logic [XW-1:0]  x_q;
    logic [YW-1:0]  y_q;
    logic           xfer;
    logic [XW-1:0]  x_d;
    logic [YW-1:0]  y_d;
`ifdef SGBM_TIMING_FRAME_CNT_EN
    logic [15:0]    frame_cnt_q;
`endif

    assign xfer = pix_valid_o & ready_i;
    assign x_d  = x_q + 1'b1;
    assign y_d  = y_q + 1'b1;

    // NOTE: sequential state is written only with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOCK;
            lock_cnt_q  <= '0;
            blank_cnt_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
`ifdef SGBM_TIMING_FRAME_CNT_EN
            frame_cnt_q <= '0;
`endif
        end else if (state_q != S_LOCK && !pll_locked_i) begin
            // Lock loss wins over any handshake in the same cycle; the frame counter survives it.
            state_q     <= S_LOCK;
            lock_cnt_q  <= '0;
            blank_cnt_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            case (state_q)
                S_LOCK: begin
                    if (!pll_locked_i) begin
                        lock_cnt_q <= '0;
                    end else if (lock_cnt_q == LOCK_LAST) begin
                        lock_cnt_q <= '0;
                        state_q    <= S_IDLE;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (enable_i) begin
                        state_q <= S_ACTIVE;
                        x_q     <= '0;
                        y_q     <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (xfer) begin
                        if (x_q != X_LAST) begin
                            x_q <= x_d;
                        end else if (y_q != Y_LAST) begin
                            x_q         <= '0;
                            y_q         <= y_d;
                            blank_cnt_q <= '0;
                            state_q     <= (H_BLANK == 0) ? S_ACTIVE : S_HBLANK;
                        end else begin
                            x_q         <= '0;
                            y_q         <= '0;
                            blank_cnt_q <= '0;
`ifdef SGBM_TIMING_FRAME_CNT_EN
                            frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
                            if (V_BLANK != 0)
                                state_q <= S_VBLANK;
                            else
                                state_q <= enable_i ? S_ACTIVE : S_IDLE;
                        end
                    end
                end
                S_HBLANK: begin
                    if (blank_cnt_q == H_LAST) begin
                        blank_cnt_q <= '0;
                        state_q     <= S_ACTIVE;
                    end else begin
                        blank_cnt_q <= blank_cnt_q + 1'b1;
                    end
                end
                S_VBLANK: begin
                    // The run request is only honoured here, so a frame is never cut short.
                    if (blank_cnt_q == V_LAST) begin
                        blank_cnt_q <= '0;
                        x_q         <= '0;
                        y_q         <= '0;
                        state_q     <= enable_i ? S_ACTIVE : S_IDLE;
                    end else begin
                        blank_cnt_q <= blank_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_LOCK;
                end
            endcase
        end
    end

    assign pix_valid_o = (state_q == S_ACTIVE);
    assign busy_o      = (state_q == S_ACTIVE) || (state_q == S_HBLANK) || (state_q == S_VBLANK);
    assign pix_x_o     = x_q;
    assign pix_y_o     = y_q;
    assign sol_o       = pix_valid_o && (x_q == '0);
    assign eol_o       = pix_valid_o && (x_q == X_LAST);
    assign sof_o       = sol_o && (y_q == '0);
    assign eof_o       = eol_o && (y_q == Y_LAST);
`ifdef SGBM_TIMING_FRAME_CNT_EN
    assign frame_cnt_o = frame_cnt_q;
`endif

endmodule
